// File: rtl/bus_capture_pkg.sv
// Shared definitions for the bus cycle capture stage: record layout, FSM states
// and the flag pattern that marks a cycle closed by the acknowledge timeout.
package bus_capture_pkg;

    localparam int RECORD_W      = 68;
    localparam int REC_ADDR_LSB  = 36;
    localparam int REC_DATA_LSB  = 4;
    localparam int REC_RW_BIT    = 3;
    localparam int REC_FLAGS_LSB = 0;

    // {berr_n, dsack1_n, dsack0_n} all high: no termination was seen
    localparam logic [2:0] TIMEOUT_FLAGS = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_AS  = 3'd1,
        ST_ADDR     = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DATA     = 3'd4,
        ST_WAIT_END = 3'd5,
        ST_COMMIT   = 3'd6
    } state_t;

    function automatic logic [RECORD_W-1:0] pack_record(
        input logic [31:0] addr,
        input logic [31:0] data,
        input logic        rw,
        input logic [2:0]  flags
    );
        logic [RECORD_W-1:0] rec;
        rec = '0;
        rec[REC_ADDR_LSB +: 32] = addr;
        rec[REC_DATA_LSB +: 32] = data;
        rec[REC_RW_BIT]         = rw;
        rec[REC_FLAGS_LSB +: 3] = flags;
        return rec;
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// Single-clock record FIFO with a registered head word; a push into an empty
// FIFO becomes visible on the following cycle (no fall-through).
module capture_fifo #(
    parameter int WIDTH      = 68,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2 + 1)'(1);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2:0]   r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_rd_ptr;
    logic [WIDTH-1:0]      r_head;

    logic                  w_push_acc;
    logic                  w_pop_acc;
    logic [DEPTH_LOG2:0]   w_rd_ptr_nxt;
    logic [DEPTH_LOG2-1:0] w_wr_idx;
    logic [DEPTH_LOG2-1:0] w_rd_idx_nxt;

    assign o_empty      = (r_wr_ptr == r_rd_ptr);
    assign o_full       = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                          (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);
    assign w_pop_acc    = i_pop && !o_empty;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign w_push_acc   = i_push && (!o_full || w_pop_acc);
    assign w_rd_ptr_nxt = w_pop_acc ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
    assign w_wr_idx     = r_wr_ptr[DEPTH_LOG2-1:0];
    assign w_rd_idx_nxt = w_rd_ptr_nxt[DEPTH_LOG2-1:0];
    assign o_head       = r_head;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            r_rd_ptr <= w_rd_ptr_nxt;
        end
    end

    // Head register tracks the slot the read pointer will point at next cycle
    always_ff @(posedge i_clk) begin
        if (w_push_acc) begin
            r_mem[w_wr_idx] <= i_push_data;
        end
        r_head <= (w_push_acc && (w_wr_idx == w_rd_idx_nxt)) ? i_push_data
                                                             : r_mem[w_rd_idx_nxt];
    end

endmodule

// File: rtl/bus_cycle_capture.sv
// Samples 68030 bus cycles through the AD transceivers and queues one 68-bit
// record per completed cycle for the downstream dump/formatter stage.
module bus_cycle_capture
    import bus_capture_pkg::*;
#(
    parameter int DEPTH_LOG2    = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int ACK_TIMEOUT   = 1023
) (
    input  logic                comm_clock,
    input  logic                comm_reset_n,
    input  logic                arm,
    input  logic                pin_as,
    input  logic                pin_ds,
    input  logic                pin_rw,
    input  logic                pin_dsack0,
    input  logic                pin_dsack1,
    input  logic                pin_berr,
    input  logic [31:0]         pin_ad,
    output logic                addr_oe_n,
    output logic                data_oe_n,
    output logic                rec_valid,
    output logic [RECORD_W-1:0] rec_data,
    input  logic                rec_ready,
    output logic                overflow,
    output logic [15:0]         drop_count,
    output logic                busy
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [9:0] TO_LIMIT    = 10'(ACK_TIMEOUT);

    logic [5:0]          r_sync_m;
    logic [5:0]          r_sync_s;
    state_t              r_state;
    logic [3:0]          r_settle;
    logic [9:0]          r_to_cnt;
    logic                r_addr_oe_n;
    logic                r_data_oe_n;
    logic                r_overflow;
    logic [15:0]         r_drop_count;
    logic [31:0]         r_addr;
    logic [31:0]         r_data;
    logic                r_rw;
    logic [2:0]          r_flags;

    state_t              w_state_nxt;
    logic                w_as_s;
    logic                w_unused_ds_s;
    logic                w_rw_s;
    logic                w_dsack0_s;
    logic                w_dsack1_s;
    logic                w_berr_s;
    logic                w_ack_seen;
    logic                w_timeout;
    logic                w_settled;
    logic                w_addr_done;
    logic                w_data_done;
    logic                w_want_addr;
    logic                w_want_data;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic                w_full;
    logic                w_empty;
    logic [RECORD_W-1:0] w_record;
    logic [RECORD_W-1:0] w_head;

    assign {w_berr_s, w_dsack1_s, w_dsack0_s, w_rw_s, w_unused_ds_s, w_as_s} = r_sync_s;

    always_ff @(posedge comm_clock) begin
        if (!comm_reset_n) begin
            r_sync_m <= '1;
            r_sync_s <= '1;
        end else begin
            r_sync_m <= {pin_berr, pin_dsack1, pin_dsack0, pin_rw, pin_ds, pin_as};
            r_sync_s <= r_sync_m;
        end
    end

    assign w_ack_seen  = !w_dsack0_s || !w_dsack1_s || !w_berr_s;
    assign w_timeout   = (r_to_cnt == TO_LIMIT);
    assign w_settled   = (r_settle == SETTLE_LAST);
    assign w_addr_done = (r_state == ST_ADDR) && !r_addr_oe_n && w_settled;
    assign w_data_done = (r_state == ST_DATA) && !r_data_oe_n && w_settled;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (arm) w_state_nxt = ST_WAIT_AS;
            ST_WAIT_AS:  if (!w_as_s) w_state_nxt = ST_ADDR;
            ST_ADDR:     if (w_addr_done) w_state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (w_ack_seen) begin
                    w_state_nxt = ST_DATA;
                end else if (w_timeout) begin
                    w_state_nxt = ST_WAIT_END;
                end
            end
            ST_DATA:     if (w_data_done) w_state_nxt = ST_WAIT_END;
            ST_WAIT_END: if (w_as_s) w_state_nxt = ST_COMMIT;
            ST_COMMIT:   w_state_nxt = ST_WAIT_AS;
            default:     w_state_nxt = ST_IDLE;
        endcase
        if ((r_state != ST_IDLE) && !arm) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Enables follow the next state; each may only turn on once the other is off
    assign w_want_addr = (w_state_nxt == ST_WAIT_AS) || (w_state_nxt == ST_ADDR);
    assign w_want_data = (w_state_nxt == ST_WAIT_ACK) || (w_state_nxt == ST_DATA) ||
                         (w_state_nxt == ST_WAIT_END);

    assign w_pop  = !w_empty && rec_ready;
    assign w_push = (r_state == ST_COMMIT) && arm;
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge comm_clock) begin
        if (!comm_reset_n) begin
            r_state      <= ST_IDLE;
            r_settle     <= '0;
            r_to_cnt     <= '0;
            r_addr_oe_n  <= 1'b1;
            r_data_oe_n  <= 1'b1;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr_oe_n <= !(w_want_addr && r_data_oe_n);
            r_data_oe_n <= !(w_want_data && r_addr_oe_n);
            // Settle time counts only while the relevant transceiver is driving
            if (w_state_nxt != r_state) begin
                r_settle <= '0;
            end else if (((r_state == ST_ADDR) && !r_addr_oe_n) ||
                         ((r_state == ST_DATA) && !r_data_oe_n)) begin
                r_settle <= r_settle + 4'd1;
            end
            if (r_state != ST_WAIT_ACK) begin
                r_to_cnt <= '0;
            end else if (!w_timeout) begin
                r_to_cnt <= r_to_cnt + 10'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 16'hFFFF) begin
                    r_drop_count <= r_drop_count + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge comm_clock) begin
        if (w_addr_done) begin
            r_addr <= pin_ad;
            r_rw   <= w_rw_s;
        end
        if (r_state == ST_WAIT_ACK) begin
            if (w_ack_seen) begin
                r_flags <= {w_berr_s, w_dsack1_s, w_dsack0_s};
            end else if (w_timeout) begin
                r_flags <= TIMEOUT_FLAGS;
                r_data  <= 32'hFFFF_FFFF;
            end
        end
        if (w_data_done) begin
            r_data <= pin_ad;
        end
    end

    assign w_record = pack_record(r_addr, r_data, r_rw, r_flags);

    capture_fifo #(
        .WIDTH      (RECORD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_clk       (comm_clock),
        .i_rst_n     (comm_reset_n),
        .i_push      (w_push),
        .i_push_data (w_record),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign addr_oe_n  = r_addr_oe_n;
    assign data_oe_n  = r_data_oe_n;
    assign rec_valid  = !w_empty;
    assign rec_data   = w_head;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bus_cycle_capture.sv
// Scoreboard bench: a bus-master model issues cycles and queues the records it
// expects; a monitor compares every record the DUT hands over.
module tb_bus_cycle_capture;

    localparam int DL    = 2;
    localparam int DEPTH = 4;
    localparam int TO    = 15;

    logic        comm_clock = 1'b0;
    logic        comm_reset_n;
    logic        arm;
    logic        pin_as, pin_ds, pin_rw, pin_dsack0, pin_dsack1, pin_berr;
    logic [31:0] pin_ad;
    logic        addr_oe_n, data_oe_n;
    logic        rec_valid;
    logic [67:0] rec_data;
    logic        rec_ready;
    logic        overflow;
    logic [15:0] drop_count;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    int          exp_drops = 0;
    logic [67:0] q_exp[$];

    bus_cycle_capture #(
        .DEPTH_LOG2    (DL),
        .SETTLE_CYCLES (2),
        .ACK_TIMEOUT   (TO)
    ) dut (
        .comm_clock   (comm_clock),
        .comm_reset_n (comm_reset_n),
        .arm          (arm),
        .pin_as       (pin_as),
        .pin_ds       (pin_ds),
        .pin_rw       (pin_rw),
        .pin_dsack0   (pin_dsack0),
        .pin_dsack1   (pin_dsack1),
        .pin_berr     (pin_berr),
        .pin_ad       (pin_ad),
        .addr_oe_n    (addr_oe_n),
        .data_oe_n    (data_oe_n),
        .rec_valid    (rec_valid),
        .rec_data     (rec_data),
        .rec_ready    (rec_ready),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .busy         (busy)
    );

    always #5 comm_clock = ~comm_clock;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: interlock every cycle, and each handed-over record against the queue
    always @(negedge comm_clock) begin
        checks++;
        if (addr_oe_n === 1'b0 && data_oe_n === 1'b0) begin
            errors++;
            $display("FAIL interlock: addr_oe_n=0 data_oe_n=0 required never both 0");
        end
        if (comm_reset_n && rec_valid && rec_ready) begin
            if (q_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_record: got %h required none", rec_data);
            end else begin
                check("record", rec_data, q_exp.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge comm_clock);
        #2;
    endtask

    task automatic wait_data_en();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (data_oe_n == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL data_enable_wait: data_oe_n=%b required 0 within 40 cycles", data_oe_n);
        end
    endtask

    task automatic release_strobes();
        pin_as = 1'b1; pin_ds = 1'b1;
        pin_dsack0 = 1'b1; pin_dsack1 = 1'b1; pin_berr = 1'b1;
    endtask

    // kind: 0 DSACK0, 1 DSACK1, 2 both DSACK, 3 BERR, 4 no acknowledge
    task automatic bus_cycle(input logic [31:0] a, input logic [31:0] d, input logic rw,
                             input int kind, input bit pop_at_commit);
        logic [2:0]  fl;
        logic [31:0] dexp;
        case (kind)
            0:       fl = 3'b110;
            1:       fl = 3'b101;
            2:       fl = 3'b100;
            3:       fl = 3'b011;
            default: fl = 3'b111;
        endcase
        dexp = (kind >= 4) ? 32'hFFFF_FFFF : d;
        pin_ad = a; pin_rw = rw; pin_ds = 1'b0; pin_as = 1'b0;
        wait_data_en();
        pin_ad = d;
        case (kind)
            0:       pin_dsack0 = 1'b0;
            1:       pin_dsack1 = 1'b0;
            2:       begin pin_dsack0 = 1'b0; pin_dsack1 = 1'b0; end
            3:       pin_berr = 1'b0;
            default: ;
        endcase
        repeat ((kind >= 4) ? TO + 12 : 8) step();
        release_strobes();
        if (q_exp.size() < DEPTH || pop_at_commit) q_exp.push_back({a, dexp, rw, fl});
        else exp_drops++;
        if (pop_at_commit) begin
            repeat (3) step();
            rec_ready = 1'b1;
            step();
            rec_ready = 1'b0;
        end
        repeat (6) step();
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        rec_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (q_exp.size() == 0 && !rec_valid) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain: pending=%0d rec_valid=%b required 0 and 0", q_exp.size(), rec_valid);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        comm_reset_n = 1'b0; arm = 1'b0; rec_ready = 1'b0;
        pin_rw = 1'b1; pin_ad = '0;
        release_strobes();
        repeat (3) step();
        check("rst_rec_valid", 68'(rec_valid), 68'(0));
        check("rst_overflow", 68'(overflow), 68'(0));
        check("rst_drop_count", 68'(drop_count), 68'(0));
        check("rst_addr_oe_n", 68'(addr_oe_n), 68'(1));
        check("rst_data_oe_n", 68'(data_oe_n), 68'(1));
        check("rst_busy", 68'(busy), 68'(0));
        comm_reset_n = 1'b1;
        step();

        rec_ready = 1'b1;
        arm = 1'b1;
        repeat (3) step();
        check("armed_busy", 68'(busy), 68'(1));
        check("armed_addr_oe_n", 68'(addr_oe_n), 68'(0));

        bus_cycle(32'h0000_1234, 32'hCAFE_F00D, 1'b1, 1, 1'b0);
        bus_cycle(32'hFFFF_0000, $urandom, 1'b0, 3, 1'b0);
        bus_cycle($urandom, $urandom, 1'b1, 4, 1'b0);
        for (int i = 0; i < 20; i++) begin
            bus_cycle($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'b0);
        end
        drain();

        // Fill the FIFO with nobody reading, then free a slot exactly at COMMIT
        rec_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus_cycle($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
        end
        check("ovf_drop_count", 68'(drop_count), 68'(exp_drops));
        check("ovf_overflow", 68'(overflow), 68'(exp_drops > 0));
        bus_cycle($urandom, $urandom, 1'b1, 0, 1'b1);
        check("pop_commit_drop_count", 68'(drop_count), 68'(exp_drops));
        drain();

        // Abort during WAIT_ACK
        pin_ad = $urandom; pin_rw = 1'b1; pin_ds = 1'b0; pin_as = 1'b0;
        wait_data_en();
        arm = 1'b0;
        step();
        check("abort_busy", 68'(busy), 68'(0));
        check("abort_addr_oe_n", 68'(addr_oe_n), 68'(1));
        check("abort_data_oe_n", 68'(data_oe_n), 68'(1));
        release_strobes();
        repeat (5) step();
        check("abort_no_record", 68'(rec_valid), 68'(0));
        check("abort_overflow_held", 68'(overflow), 68'(1));
        check("abort_drops_held", 68'(drop_count), 68'(exp_drops));
        arm = 1'b1;
        repeat (3) step();
        bus_cycle($urandom, $urandom, 1'b0, 2, 1'b0);
        drain();

        // Reset in the middle of a DATA phase with records waiting
        rec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_cycle($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
        end
        check("queued_valid", 68'(rec_valid), 68'(1));
        pin_ad = $urandom; pin_rw = 1'b0; pin_ds = 1'b0; pin_as = 1'b0;
        wait_data_en();
        pin_dsack0 = 1'b0;
        repeat (3) step();
        comm_reset_n = 1'b0;
        step();
        check("midrst_rec_valid", 68'(rec_valid), 68'(0));
        check("midrst_drop_count", 68'(drop_count), 68'(0));
        check("midrst_overflow", 68'(overflow), 68'(0));
        check("midrst_addr_oe_n", 68'(addr_oe_n), 68'(1));
        check("midrst_data_oe_n", 68'(data_oe_n), 68'(1));
        check("midrst_busy", 68'(busy), 68'(0));
        q_exp.delete();
        exp_drops = 0;
        comm_reset_n = 1'b1;
        release_strobes();
        repeat (4) step();
        rec_ready = 1'b1;
        bus_cycle($urandom, $urandom, 1'b1, 1, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
